// File: rtl/id_ex_forward_stage.sv
// ID/EX + EX/MEM pipeline registers with stall/flush bubble insertion,
// EX operand forwarding and a sticky stall watchdog.

module fwd_operand_mux #(
  parameter int XLEN = 32
) (
  input  logic            valid,
  input  logic            fwd_ex,
  input  logic            fwd_mem,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] exmem,
  input  logic [XLEN-1:0] wb,
  output logic [XLEN-1:0] op
);
  // Youngest producer wins: EX/MEM beats MEM/WB; bubbles drive zero.
  always_comb begin
    op = '0;
    if (valid) begin
      if (fwd_ex)       op = exmem;
      else if (fwd_mem) op = wb;
      else              op = rs;
    end
  end
endmodule

module id_ex_forward_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            fwd_ex_ex1,
  input  logic            fwd_ex_ex2,
  input  logic            fwd_mem_ex1,
  input  logic            fwd_mem_ex2,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [4:0]      id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic            ex_valid,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic [XLEN-1:0] exmem_result,
  output logic            if_id_hold,
  output logic            stall_err
);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STALL_LIMIT);

  typedef struct packed {
    logic                 valid;
    logic [4:0]           rd;
    logic                 reg_write;
    logic                 mem_read;
    logic [1:0]           fwd_ex;
    logic [1:0]           fwd_mem;
    logic [1:0][XLEN-1:0] rs;
  } idex_t;

  idex_t                idex_d, idex_q;
  logic [1:0][XLEN-1:0] ops;
  logic [CW-1:0]        stall_cnt, cnt_nxt;

  // Forward flags travel with the instruction they qualify.
  always_comb begin
    idex_d = '0;
    if (!(flush || stall)) begin
      idex_d.valid     = id_valid;
      idex_d.rd        = id_rd;
      idex_d.reg_write = id_reg_write;
      idex_d.mem_read  = id_mem_read;
      idex_d.fwd_ex    = {fwd_ex_ex2, fwd_ex_ex1};
      idex_d.fwd_mem   = {fwd_mem_ex2, fwd_mem_ex1};
      idex_d.rs        = {id_rs2_data, id_rs1_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               exmem_result <= '0;
    else if (idex_q.valid) exmem_result <= ex_alu_result;
  end

  genvar i;
  generate
    for (i = 0; i < 2; i++) begin : g_op
      fwd_operand_mux #(.XLEN(XLEN)) u_mux (
        .valid   (idex_q.valid),
        .fwd_ex  (idex_q.fwd_ex[i]),
        .fwd_mem (idex_q.fwd_mem[i]),
        .rs      (idex_q.rs[i]),
        .exmem   (exmem_result),
        .wb      (wb_data),
        .op      (ops[i])
      );
    end
  endgenerate

  always_comb begin
    cnt_nxt = '0;
    if (stall && !flush)
      cnt_nxt = (stall_cnt == LIM) ? stall_cnt : stall_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      stall_err <= 1'b0;
    end else begin
      stall_cnt <= cnt_nxt;
      stall_err <= stall_err | (cnt_nxt == LIM);
    end
  end

  assign ex_op1       = ops[0];
  assign ex_op2       = ops[1];
  assign ex_valid     = idex_q.valid;
  assign ex_rd        = idex_q.rd;
  assign ex_reg_write = idex_q.reg_write;
  assign ex_mem_read  = idex_q.mem_read;
  // Hold must drop the instant reset asserts, not at the next edge.
  assign if_id_hold   = stall & ~flush & ~rst;
endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Directed bench: stimulus pushes expected values tagged with a cycle number,
// a negedge monitor pops and compares them against the DUT.

module tb_id_ex_forward_stage;
  logic        clk, rst, stall, flush;
  logic        fwd_ex_ex1, fwd_ex_ex2, fwd_mem_ex1, fwd_mem_ex2;
  logic        id_valid, id_reg_write, id_mem_read;
  logic [31:0] id_rs1_data, id_rs2_data, ex_alu_result, wb_data;
  logic [4:0]  id_rd, ex_rd;
  logic [31:0] ex_op1, ex_op2, exmem_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, if_id_hold, stall_err;

  id_ex_forward_stage #(.XLEN(32), .STALL_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .fwd_ex_ex1(fwd_ex_ex1), .fwd_ex_ex2(fwd_ex_ex2),
    .fwd_mem_ex1(fwd_mem_ex1), .fwd_mem_ex2(fwd_mem_ex2),
    .id_valid(id_valid), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_alu_result(ex_alu_result), .wb_data(wb_data),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .exmem_result(exmem_result), .if_id_hold(if_id_hold), .stall_err(stall_err)
  );

  localparam int S_VLD = 0, S_OP1 = 1, S_OP2 = 2, S_RD = 3, S_RW = 4,
                 S_MR = 5, S_EXM = 6, S_HOLD = 7, S_ERR = 8;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_VLD:  return {31'd0, ex_valid};
      S_OP1:  return ex_op1;
      S_OP2:  return ex_op2;
      S_RD:   return {27'd0, ex_rd};
      S_RW:   return {31'd0, ex_reg_write};
      S_MR:   return {31'd0, ex_mem_read};
      S_EXM:  return exmem_result;
      S_HOLD: return {31'd0, if_id_hold};
      default: return {31'd0, stall_err};
    endcase
  endfunction

  function automatic string sname(int sel);
    case (sel)
      S_VLD:  return "ex_valid";
      S_OP1:  return "ex_op1";
      S_OP2:  return "ex_op2";
      S_RD:   return "ex_rd";
      S_RW:   return "ex_reg_write";
      S_MR:   return "ex_mem_read";
      S_EXM:  return "exmem_result";
      S_HOLD: return "if_id_hold";
      default: return "stall_err";
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = actual(mon_e.sel);
      checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h expected=%h", sname(mon_e.sel), mon_e.cyc, mon_act, mon_e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp(input int dc, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + dc;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic instr(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic [3:0] f);
    id_valid = 1'b1; id_rs1_data = r1; id_rs2_data = r2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr;
    {fwd_ex_ex1, fwd_ex_ex2, fwd_mem_ex1, fwd_mem_ex2} = f;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; flush = 1'b0;
    {fwd_ex_ex1, fwd_ex_ex2, fwd_mem_ex1, fwd_mem_ex2} = 4'b0;
    id_valid = 1'b0; id_rs1_data = '0; id_rs2_data = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; ex_alu_result = '0; wb_data = '0;

    // reset state, hold gated by reset even with stall high
    tick();
    exp(0, S_HOLD, 0); exp(0, S_VLD, 0); exp(0, S_OP1, 0); exp(0, S_OP2, 0);
    exp(0, S_EXM, 0); exp(0, S_ERR, 0);
    tick(); rst = 1'b0; stall = 1'b0;
    tick(); exp(0, S_VLD, 0);

    // instr1: plain regfile operands
    instr(32'h5, 32'hB, 5'd1, 1'b1, 1'b0, 4'b0000); ex_alu_result = 32'h10;
    exp(1, S_VLD, 1); exp(1, S_RD, 1); exp(1, S_RW, 1); exp(1, S_OP1, 32'h5); exp(1, S_OP2, 32'hB);
    // instr2: rs1 from EX/MEM
    tick(); instr(32'hFF, 32'h7, 5'd2, 1'b1, 1'b0, 4'b1000);
    exp(1, S_OP1, 32'h10); exp(1, S_OP2, 32'h7); exp(1, S_EXM, 32'h10);
    // instr3: both rs2 flags, EX wins
    tick(); instr(32'h1, 32'h44, 5'd3, 1'b1, 1'b0, 4'b0101);
    wb_data = 32'h22; ex_alu_result = 32'h33;
    exp(1, S_OP2, 32'h33); exp(1, S_OP1, 32'h1);
    // instr4: MEM/WB for both operands
    tick(); instr(32'h66, 32'h55, 5'd4, 1'b1, 1'b0, 4'b0011); ex_alu_result = 32'h99;
    exp(1, S_OP2, 32'h22); exp(1, S_OP1, 32'h22); exp(1, S_EXM, 32'h99);
    // instr5 load-use stall for one cycle
    tick(); instr(32'hA, 32'hB, 5'd5, 1'b1, 1'b0, 4'b0000); stall = 1'b1;
    exp(0, S_HOLD, 1); exp(1, S_VLD, 0); exp(1, S_RW, 0); exp(1, S_OP1, 0);
    tick(); stall = 1'b0; ex_alu_result = 32'h77;
    exp(0, S_HOLD, 0); exp(1, S_VLD, 1); exp(1, S_RD, 5); exp(1, S_OP1, 32'hA); exp(1, S_EXM, 32'h99);
    // flush and stall together
    tick(); instr(32'h3, 32'h4, 5'd6, 1'b1, 1'b1, 4'b1111); stall = 1'b1; flush = 1'b1;
    exp(0, S_HOLD, 0); exp(1, S_VLD, 0); exp(1, S_MR, 0); exp(1, S_RW, 0); exp(1, S_EXM, 32'h77);
    // three stall edges after the flush cycle must not trip the watchdog
    tick(); flush = 1'b0; exp(0, S_ERR, 0);
    tick(); tick();
    tick(); stall = 1'b0; exp(0, S_ERR, 0);
    // four stall edges trip it, and it stays set
    tick(); stall = 1'b1; exp(0, S_HOLD, 1);
    tick(); tick();
    tick(); exp(0, S_ERR, 0);
    tick(); stall = 1'b0; exp(0, S_ERR, 1);
    tick(); exp(0, S_ERR, 1); exp(0, S_HOLD, 0);
    // asynchronous reset in the middle of a stall
    tick(); stall = 1'b1; rst = 1'b1;
    exp(0, S_HOLD, 0); exp(0, S_ERR, 0); exp(0, S_VLD, 0); exp(0, S_EXM, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
